// File: rtl/i2c_lcd_arbiter.sv
// Round-robin arbiter sharing one i2c_master command port between two 3-byte LCD writers.
// Define I2C_ARB_TIMEOUT_EN to abort a wait whose done never arrives and flag it on err.
module i2c_lcd_arbiter #(
  parameter logic [7:0]  LCD_ADDR     = 8'h7c,
  parameter logic [15:0] DONE_HOLDOFF = 16'd2,
  parameter logic [15:0] END_GAP      = 16'h0300,
  parameter logic [15:0] TIMEOUT      = 16'h1000
) (
  input  logic       ioclk,
  input  logic       res,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] ctrl0,
  input  logic [7:0] ctrl1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic       err,
  output logic       busy,
  output logic       write,
  output logic       send,
  output logic       start,
  output logic       endcomm,
  output logic [7:0] byte_o,
  input  logic       done
);

  typedef enum logic [3:0] {
    S_IDLE, S_GRANT, S_START_ISSUE, S_START_WAIT, S_LOAD,
    S_SEND, S_SEND_WAIT, S_STOP, S_GAP, S_FINISH
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        rr_q, rr_d;
  logic        gnt_q, gnt_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  byte_d;
  logic        win;
  logic        wait_ok;
  logic        start_q, write_q, send_q, endcomm_q, busy_q, ack0_q, ack1_q;
  logic [7:0]  byte_q;
`ifdef I2C_ARB_TIMEOUT_EN
  logic        abort_q, abort_d, err_q;
`endif

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

  // Next-state logic; wait counters hold 1 in the first wait cycle so they count cycles spent waiting
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    win     = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
    abort_d = abort_q;
`endif
    wait_ok = (cnt_q >= DONE_HOLDOFF) && done;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) state_d = S_GRANT;
        else              state_d = S_IDLE;
      end
      S_GRANT: begin
        if (req0 && req1) win = rr_q;
        else              win = req1;
        gnt_d   = win;
        ctrl_d  = win ? ctrl1 : ctrl0;
        data_d  = win ? data1 : data0;
        idx_d   = 2'd0;
        rr_d    = ~win;
`ifdef I2C_ARB_TIMEOUT_EN
        abort_d = 1'b0;
`endif
        state_d = S_START_ISSUE;
      end
      S_START_ISSUE: begin
        cnt_d   = 16'd1;
        state_d = S_START_WAIT;
      end
      S_START_WAIT: begin
        if (wait_ok) state_d = S_LOAD;
`ifdef I2C_ARB_TIMEOUT_EN
        else if (cnt_q >= TIMEOUT) begin
          abort_d = 1'b1;
          state_d = S_STOP;
        end
`endif
        else cnt_d = sat_inc(cnt_q);
      end
      S_LOAD: state_d = S_SEND;
      S_SEND: begin
        cnt_d   = 16'd1;
        state_d = S_SEND_WAIT;
      end
      S_SEND_WAIT: begin
        if (wait_ok) begin
          idx_d   = idx_q + 2'd1;
          state_d = (idx_q == 2'd2) ? S_STOP : S_LOAD;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (cnt_q >= TIMEOUT) begin
          abort_d = 1'b1;
          state_d = S_STOP;
        end
`endif
        else cnt_d = sat_inc(cnt_q);
      end
      S_STOP: begin
        cnt_d   = 16'd1;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (cnt_q >= END_GAP) state_d = S_FINISH;
        else                  cnt_d   = sat_inc(cnt_q);
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Byte presented to the master, selected for the cycle the FSM spends in LOAD
  always_comb begin
    byte_d = 8'h00;
    if (state_d == S_LOAD) begin
      case (idx_d)
        2'd0:    byte_d = LCD_ADDR;
        2'd1:    byte_d = ctrl_d;
        2'd2:    byte_d = data_d;
        default: byte_d = 8'h00;
      endcase
    end else begin
      byte_d = 8'h00;
    end
  end

  // State, datapath and registered strobes decoded from the next state
  always_ff @(posedge ioclk) begin
    if (res) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      idx_q     <= 2'd0;
      rr_q      <= 1'b0;
      gnt_q     <= 1'b0;
      ctrl_q    <= 8'h00;
      data_q    <= 8'h00;
      start_q   <= 1'b0;
      write_q   <= 1'b0;
      send_q    <= 1'b0;
      endcomm_q <= 1'b0;
      busy_q    <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      byte_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      ctrl_q    <= ctrl_d;
      data_q    <= data_d;
      start_q   <= (state_d == S_START_ISSUE);
      write_q   <= (state_d == S_LOAD);
      send_q    <= (state_d == S_SEND);
      endcomm_q <= (state_d == S_STOP);
      busy_q    <= (state_d != S_IDLE);
      ack0_q    <= (state_d == S_FINISH) && !gnt_d;
      ack1_q    <= (state_d == S_FINISH) && gnt_d;
      byte_q    <= byte_d;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  // Abort flag rides through STOP/GAP so err pulses together with ack
  always_ff @(posedge ioclk) begin
    if (res) begin
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      abort_q <= abort_d;
      err_q   <= (state_d == S_FINISH) && abort_d;
    end
  end
  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign err = 1'b0;
`endif

  assign start   = start_q;
  assign write   = write_q;
  assign send    = send_q;
  assign endcomm = endcomm_q;
  assign busy    = busy_q;
  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign byte_o  = byte_q;

endmodule
